riscv_bitops_unit: RTL

Multi-cycle execution unit for the custom bit-operation instructions: BITCOUNT (population count) and REVERSE (bit reversal) of a 32-bit operand.
- Sits in the EX stage beside the multiplier.
- Receives enable/operator/operand from the decoder/ID-EX registers.
- Returns the result to the EX writeback mux with the same ready_o/ex_ready_i multicycle handshake the multiplier uses.
- Processes BITS_PER_CYCLE operand bits per cycle, so area and latency trade off through one parameter.

---
 rtl/riscv_defines.sv | 22 ++
 rtl/riscv_bitops_chunk.sv | 30 +++
 rtl/riscv_bitops_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
// riscv_defines
//   Shared constants and types for the EX-stage execution units.
//   Holds the bit-op operator encodings and the bit-op unit state type.
//   Contents:
//     BIT_OP_WIDTH, BIT_OP_BITCOUNT, BIT_OP_REVERSE : operator_i encoding
//     BITOPS_DATA_WIDTH                             : operand/result width
//     bitops_state_e                                : bit-op unit FSM states
package riscv_defines;

  localparam int BIT_OP_WIDTH = 2;
  localparam logic [BIT_OP_WIDTH-1:0] BIT_OP_BITCOUNT = 2'd0;
  localparam logic [BIT_OP_WIDTH-1:0] BIT_OP_REVERSE  = 2'd1;

  localparam int BITOPS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    BITOPS_IDLE = 2'd0,
    BITOPS_BUSY = 2'd1,
    BITOPS_DONE = 2'd2
  } bitops_state_e;

endpackage

// File: rtl/riscv_bitops_chunk.sv
// riscv_bitops_chunk
//   Purely combinational per-chunk helper for the bit-op unit.
//   Ports:
//     chunk_i    [WIDTH]          : operand slice consumed this cycle
//     popcount_o [$clog2(WIDTH)+1] : number of set bits in chunk_i
//     bitrev_o   [WIDTH]          : chunk_i with its bit order reversed
module riscv_bitops_chunk #(
  parameter  int WIDTH = 8,
  localparam int PC_W  = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] chunk_i,
  output logic [PC_W-1:0]  popcount_o,
  output logic [WIDTH-1:0] bitrev_o
);

  always_comb begin
    popcount_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcount_o = popcount_o + PC_W'(chunk_i[i]);
    end
  end

  always_comb begin
    bitrev_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bitrev_o[i] = chunk_i[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/riscv_bitops_unit.sv
// riscv_bitops_unit
//   Multi-cycle EX-stage unit for BITCOUNT (population count) and REVERSE
//   (bit reversal) of a 32-bit operand, BITS_PER_CYCLE bits per BUSY cycle.
//   Uses the same ready_o / ex_ready_i handshake as the multiplier.
//   Ports:
//     clk, rst_n  : core clock, asynchronous active-low reset
//     enable_i    : bit-op instruction present in EX
//     operator_i  : BIT_OP_BITCOUNT or BIT_OP_REVERSE
//     operand_i   : source operand (rs1), latched on acceptance
//     ex_ready_i  : pipeline takes the result this cycle
//     result_o    : result, valid while ready_o=1 in DONE (0 elsewhere)
//     ready_o     : unit can accept / result available
//     busy_o      : high in BUSY and DONE
module riscv_bitops_unit
  import riscv_defines::*;
#(
  parameter  int BITS_PER_CYCLE = 8,
  localparam int NUM_CHUNKS     = BITOPS_DATA_WIDTH / BITS_PER_CYCLE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable_i,
  input  logic [BIT_OP_WIDTH-1:0]      operator_i,
  input  logic [BITOPS_DATA_WIDTH-1:0] operand_i,
  input  logic                         ex_ready_i,
  output logic [BITOPS_DATA_WIDTH-1:0] result_o,
  output logic                         ready_o,
  output logic                         busy_o
);

  localparam int DW    = BITOPS_DATA_WIDTH;
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int PC_W  = $clog2(BPC) + 1;
  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8 && BPC != 16 && BPC != 32) begin : g_bad_bpc
    $error("riscv_bitops_unit: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
  end

  bitops_state_e           state_q;
  logic [DW-1:0]           shift_q;
  logic [DW-1:0]           acc_q;
  logic [BIT_OP_WIDTH-1:0] op_q;
  logic [CNT_W-1:0]        cnt_q;

  logic                    known_op;
  logic                    start;
  logic [PC_W-1:0]         chunk_pc;
  logic [BPC-1:0]          chunk_rev;
  logic [DW-1:0]           shift_nxt;
  logic [DW-1:0]           acc_pop;
  logic [DW-1:0]           acc_rev;

  assign known_op = (operator_i == BIT_OP_BITCOUNT) || (operator_i == BIT_OP_REVERSE);
  assign start    = (state_q == BITOPS_IDLE) && enable_i && known_op;

  // Unknown operators are a single-cycle no-op: ready stays high in IDLE.
  assign ready_o  = (state_q == BITOPS_IDLE) ? ~(enable_i & known_op)
                                             : (state_q == BITOPS_DONE);
  assign busy_o   = (state_q != BITOPS_IDLE);
  // Gated so no partial or stale accumulator value ever leaves the unit.
  assign result_o = (state_q == BITOPS_DONE) ? acc_q : '0;

  riscv_bitops_chunk #(
    .WIDTH (BPC)
  ) u_chunk (
    .chunk_i    (shift_q[BPC-1:0]),
    .popcount_o (chunk_pc),
    .bitrev_o   (chunk_rev)
  );

  assign acc_pop = acc_q + {{(DW-PC_W){1'b0}}, chunk_pc};

  // The LSB chunk is consumed first; for REVERSE its reversed bits belong
  // at the top of the result, so earlier chunks are shifted up as later
  // ones are appended below.
  if (BPC == DW) begin : g_full_width
    assign shift_nxt = '0;
    assign acc_rev   = chunk_rev;
  end else begin : g_chunked
    assign shift_nxt = {{BPC{1'b0}}, shift_q[DW-1:BPC]};
    assign acc_rev   = {acc_q[DW-BPC-1:0], chunk_rev};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BITOPS_IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      op_q    <= BIT_OP_BITCOUNT;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        BITOPS_IDLE: begin
          if (start) begin
            shift_q <= operand_i;
            acc_q   <= '0;
            op_q    <= operator_i;
            cnt_q   <= CNT_W'(NUM_CHUNKS - 1);
            state_q <= BITOPS_BUSY;
          end
        end
        BITOPS_BUSY: begin
          shift_q <= shift_nxt;
          acc_q   <= (op_q == BIT_OP_BITCOUNT) ? acc_pop : acc_rev;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= BITOPS_DONE;
          end
        end
        BITOPS_DONE: begin
          if (ex_ready_i) begin
            state_q <= BITOPS_IDLE;
          end
        end
        default: state_q <= BITOPS_IDLE;
      endcase
    end
  end

  a_no_ready_in_busy : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == BITOPS_BUSY) |-> !ready_o);

  a_bitcount_range : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == BITOPS_DONE && op_q == BIT_OP_BITCOUNT) |-> (acc_q <= 32'd32));

  a_legal_state : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == BITOPS_IDLE) || (state_q == BITOPS_BUSY) || (state_q == BITOPS_DONE));

endmodule
